// File: rtl/multi_read_port_ram_if.sv
// Bus bundle for multi_read_port_ram: one write port, NRD read ports, busy flag.
interface multi_read_port_ram_if #(
   parameter int DW  = 32,
   parameter int AW  = 5,
   parameter int NRD = 2
);
   logic                   i_we;
   logic [AW-1:0]          i_waddr;
   logic [DW-1:0]          i_wdata;
   logic [NRD-1:0][AW-1:0] i_raddr;
   logic [NRD-1:0][DW-1:0] o_rdata;
   logic                   o_busy;

   modport master (
      output i_we, i_waddr, i_wdata, i_raddr,
      input  o_rdata, o_busy
   );

   modport slave (
      input  i_we, i_waddr, i_wdata, i_raddr,
      output o_rdata, o_busy
   );
endinterface

// File: rtl/multi_read_port_ram.sv
// Register-file RAM: one synchronous write port, NRD registered read ports,
// optional write-to-read bypass, optional hardwired-zero entry 0 and a
// post-reset clear sweep that zeroes every entry while o_busy is high.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | normal operation: writes accepted, reads return array data
// S_CLEAR | sweeping mem[cnt] <= 0; writes dropped, reads return 0
module multi_read_port_ram #(
   parameter int DW         = 32,
   parameter int AW         = 5,
   parameter int NRD        = 2,
   parameter bit BYPASS     = 1'b1,
   parameter bit ZERO_R0    = 1'b0,
   parameter bit CLR_ON_RST = 1'b1
) (
   input logic                  clk,
   input logic                  rst,
   multi_read_port_ram_if.slave bus
);
   localparam int DEPTH = 2 ** AW;

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t                 state;
   logic [AW-1:0]          cnt;
   logic                   busy_q;
   logic [DW-1:0]          mem [DEPTH];
   logic [NRD-1:0][DW-1:0] rdata_q;
   logic                   wr_ok;

   // A user write lands only in IDLE, outside reset, and never into a hardwired-zero entry 0.
   assign wr_ok = bus.i_we && !rst && (state == S_IDLE) &&
                  !(ZERO_R0 && (bus.i_waddr == '0));

   // Clear-sweep FSM: reset (re)starts the sweep at address 0; last entry returns to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         if (CLR_ON_RST) begin
            state  <= S_CLEAR;
            busy_q <= 1'b1;
         end else begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
         end
      end else begin
         case (state)
            S_CLEAR: begin
               cnt <= cnt + 1'b1;
               if (cnt == {AW{1'b1}}) begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   // Array write: sweep writes zeros; reset alone leaves contents untouched.
   always_ff @(posedge clk) begin
      if (!rst && (state == S_CLEAR)) begin
         mem[cnt] <= '0;
      end else if (wr_ok) begin
         mem[bus.i_waddr] <= bus.i_wdata;
      end
   end

   // Per-port registered read; each port does its own bypass compare against the write port.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NRD; k++) begin
         if (rst || (state == S_CLEAR)) begin
            rdata_q[k] <= '0;
         end else if (ZERO_R0 && (bus.i_raddr[k] == '0)) begin
            rdata_q[k] <= '0;
         end else if (BYPASS && bus.i_we && (bus.i_waddr == bus.i_raddr[k])) begin
            rdata_q[k] <= bus.i_wdata;
         end else begin
            rdata_q[k] <= mem[bus.i_raddr[k]];
         end
      end
   end

   assign bus.o_rdata = rdata_q;
   assign bus.o_busy  = busy_q;
endmodule
